conv_mac_engine: RTL and testbench



---
 rtl/conv_mac_engine.sv | 164 ++++++++++++++++
 tb/tb_conv_mac_engine.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/conv_mac_engine.sv
// 3x3 valid convolution over a 4x4 unsigned image, one multiply-accumulate per cycle.
// Operands are snapshotted on launch; the four 2x2 results are written as each 9-term sum completes.
module conv_mac_engine #(
    parameter int DATA_W = 8,
    parameter int ACC_W  = 20
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] input_data0,
    input  logic [DATA_W-1:0] input_data1,
    input  logic [DATA_W-1:0] input_data2,
    input  logic [DATA_W-1:0] input_data3,
    input  logic [DATA_W-1:0] input_data4,
    input  logic [DATA_W-1:0] input_data5,
    input  logic [DATA_W-1:0] input_data6,
    input  logic [DATA_W-1:0] input_data7,
    input  logic [DATA_W-1:0] input_data8,
    input  logic [DATA_W-1:0] input_data9,
    input  logic [DATA_W-1:0] input_data10,
    input  logic [DATA_W-1:0] input_data11,
    input  logic [DATA_W-1:0] input_data12,
    input  logic [DATA_W-1:0] input_data13,
    input  logic [DATA_W-1:0] input_data14,
    input  logic [DATA_W-1:0] input_data15,
    input  logic [DATA_W-1:0] filter_data0,
    input  logic [DATA_W-1:0] filter_data1,
    input  logic [DATA_W-1:0] filter_data2,
    input  logic [DATA_W-1:0] filter_data3,
    input  logic [DATA_W-1:0] filter_data4,
    input  logic [DATA_W-1:0] filter_data5,
    input  logic [DATA_W-1:0] filter_data6,
    input  logic [DATA_W-1:0] filter_data7,
    input  logic [DATA_W-1:0] filter_data8,
    output logic              busy,
    output logic              done,
    output logic [ACC_W-1:0]  out0,
    output logic [ACC_W-1:0]  out1,
    output logic [ACC_W-1:0]  out2,
    output logic [ACC_W-1:0]  out3
);

    typedef enum logic [1:0] {S_IDLE, S_MAC, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [DATA_W-1:0]   img_q [16];
    logic [DATA_W-1:0]   img_d [16];
    logic [DATA_W-1:0]   flt_q [9];
    logic [DATA_W-1:0]   flt_d [9];
    logic [DATA_W-1:0]   img_in [16];
    logic [DATA_W-1:0]   flt_in [9];
    logic [ACC_W-1:0]    out_q [4];
    logic [ACC_W-1:0]    out_d [4];
    logic [ACC_W-1:0]    acc_q, acc_d, acc_sum;
    logic [1:0]          o_q, o_d, kr_q, kr_d, kc_q, kc_d;
    logic [1:0]          row, col;
    logic [3:0]          fidx;
    logic [2*DATA_W-1:0] prod;
    logic                launch, last;

    function automatic logic [ACC_W-1:0] zext_prod(input logic [2*DATA_W-1:0] p);
        return ACC_W'(p);
    endfunction

    always_comb begin
        img_in = '{input_data0, input_data1, input_data2, input_data3,
                   input_data4, input_data5, input_data6, input_data7,
                   input_data8, input_data9, input_data10, input_data11,
                   input_data12, input_data13, input_data14, input_data15};
        flt_in = '{filter_data0, filter_data1, filter_data2, filter_data3, filter_data4,
                   filter_data5, filter_data6, filter_data7, filter_data8};
    end

    // DONE accepts start directly so a held start repeats every 37 cycles.
    assign launch = start && (state_q == S_IDLE || state_q == S_DONE);
    assign last   = (state_q == S_MAC) && (o_q == 2'd3) && (kr_q == 2'd2) && (kc_q == 2'd2);

    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start) state_d = S_MAC;
            S_MAC:   if (last)  state_d = S_DONE;
            S_DONE:  state_d = start ? S_MAC : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == S_MAC);
        done = (state_q == S_DONE);
    end

    // Window element (r + kr, c + kc) where r = o[1], c = o[0].
    always_comb begin
        row     = {1'b0, o_q[1]} + kr_q;
        col     = {1'b0, o_q[0]} + kc_q;
        fidx    = ({2'b00, kr_q} * 4'd3) + {2'b00, kc_q};
        prod    = img_q[{row, col}] * flt_q[fidx];
        acc_sum = ((kr_q == 2'd0 && kc_q == 2'd0) ? '0 : acc_q) + zext_prod(prod);
    end

    always_comb begin
        img_d = img_q;
        flt_d = flt_q;
        out_d = out_q;
        acc_d = acc_q;
        o_d   = o_q;
        kr_d  = kr_q;
        kc_d  = kc_q;
        if (launch) begin
            img_d = img_in;
            flt_d = flt_in;
            acc_d = '0;
            o_d   = '0;
            kr_d  = '0;
            kc_d  = '0;
        end else if (state_q == S_MAC) begin
            acc_d = acc_sum;
            if (kc_q == 2'd2) begin
                kc_d = '0;
                if (kr_q == 2'd2) begin
                    kr_d       = '0;
                    o_d        = o_q + 2'd1;
                    out_d[o_q] = acc_sum;
                end else begin
                    kr_d = kr_q + 2'd1;
                end
            end else begin
                kc_d = kc_q + 2'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            img_q <= '{default: '0};
            flt_q <= '{default: '0};
            out_q <= '{default: '0};
            acc_q <= '0;
            o_q   <= '0;
            kr_q  <= '0;
            kc_q  <= '0;
        end else begin
            img_q <= img_d;
            flt_q <= flt_d;
            out_q <= out_d;
            acc_q <= acc_d;
            o_q   <= o_d;
            kr_q  <= kr_d;
            kc_q  <= kc_d;
        end
    end

    assign out0 = out_q[0];
    assign out1 = out_q[1];
    assign out2 = out_q[2];
    assign out3 = out_q[3];

endmodule

// File: tb/tb_conv_mac_engine.sv
// Directed bench for conv_mac_engine: baseline, saturation, operand isolation,
// mid-run reset, back-to-back runs and start ignored during a run.
module tb_conv_mac_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [7:0]  img [16];
    logic [7:0]  flt [9];
    logic        busy, done;
    logic [19:0] o0, o1, o2, o3;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    localparam int B0 = 104680, B1 = 150974, B2 = 152037, B3 = 188350, SAT = 585225;

    conv_mac_engine #(.DATA_W(8), .ACC_W(20)) dut (
        .clk(clk), .rst(rst), .start(start),
        .input_data0(img[0]),   .input_data1(img[1]),   .input_data2(img[2]),   .input_data3(img[3]),
        .input_data4(img[4]),   .input_data5(img[5]),   .input_data6(img[6]),   .input_data7(img[7]),
        .input_data8(img[8]),   .input_data9(img[9]),   .input_data10(img[10]), .input_data11(img[11]),
        .input_data12(img[12]), .input_data13(img[13]), .input_data14(img[14]), .input_data15(img[15]),
        .filter_data0(flt[0]), .filter_data1(flt[1]), .filter_data2(flt[2]),
        .filter_data3(flt[3]), .filter_data4(flt[4]), .filter_data5(flt[5]),
        .filter_data6(flt[6]), .filter_data7(flt[7]), .filter_data8(flt[8]),
        .busy(busy), .done(done),
        .out0(o0), .out1(o1), .out2(o2), .out3(o3)
    );

    initial forever #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input int e0, input int e1, input int e2, input int e3);
        chk({tag, "_out0"}, 64'(o0), 64'(e0));
        chk({tag, "_out1"}, 64'(o1), 64'(e1));
        chk({tag, "_out2"}, 64'(o2), 64'(e2));
        chk({tag, "_out3"}, 64'(o3), 64'(e3));
    endtask

    task automatic set_baseline();
        img = '{145, 37, 19, 86, 190, 227, 126, 234, 232, 117, 92, 232, 128, 105, 153, 204};
        flt = '{18, 116, 231, 139, 13, 188, 51, 132, 142};
    endtask

    task automatic set_all(input logic [7:0] v);
        for (int i = 0; i < 16; i++) img[i] = v;
        for (int i = 0; i < 9; i++) flt[i] = v;
    endtask

    // Drives a one-cycle start; returns just after E0.
    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int done_cnt;
        int done_t [$];
        bit busy_late;

        rst   = 1'b1;
        start = 1'b0;
        set_all(8'd0);
        ticks(2);
        rst = 1'b0;
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(done), 64'd0);
        chk_outs("reset", 0, 0, 0, 0);

        // Idle with start low: nothing moves
        ticks(3);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_done", 64'(done), 64'd0);

        // Baseline, with exact write edge of out0 and done timing
        set_baseline();
        pulse_start();
        chk("base_busy_e0", 64'(busy), 64'd1);
        ticks(8);
        chk("base_out0_e8", 64'(o0), 64'd0);
        tick();
        chk("base_out0_e9", 64'(o0), 64'(B0));
        chk("base_out1_e9", 64'(o1), 64'd0);
        ticks(26);
        chk("base_done_e35", 64'(done), 64'd0);
        chk("base_busy_e35", 64'(busy), 64'd1);
        tick();
        chk("base_done_e36", 64'(done), 64'd1);
        chk("base_busy_e36", 64'(busy), 64'd0);
        chk_outs("base", B0, B1, B2, B3);
        tick();
        chk("base_done_e37", 64'(done), 64'd0);
        chk("base_busy_e37", 64'(busy), 64'd0);

        // Saturation: all operands at full scale
        set_all(8'd255);
        pulse_start();
        ticks(36);
        chk("sat_done", 64'(done), 64'd1);
        chk_outs("sat", SAT, SAT, SAT, SAT);
        tick();

        // Operand isolation: inputs zeroed right after the snapshot
        set_baseline();
        pulse_start();
        set_all(8'd0);
        ticks(36);
        chk("iso_done", 64'(done), 64'd1);
        chk_outs("iso", B0, B1, B2, B3);
        tick();

        // Reset at E20 aborts the run
        set_baseline();
        pulse_start();
        ticks(19);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk_outs("rst", 0, 0, 0, 0);
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (done) done_cnt++;
        end
        chk("rst_no_done", 64'(done_cnt), 64'd0);
        chk_outs("rst_hold", 0, 0, 0, 0);

        // Start on the first edge after a one-cycle reset is accepted
        rst = 1'b1;
        tick();
        rst = 1'b0;
        pulse_start();
        chk("restart_busy", 64'(busy), 64'd1);
        ticks(36);
        chk("restart_done", 64'(done), 64'd1);
        chk_outs("restart", B0, B1, B2, B3);
        tick();

        // Back-to-back: start held; third run uses full-scale operands
        set_baseline();
        start = 1'b1;
        tick();
        done_t.delete();
        for (int i = 1; i <= 110; i++) begin
            if (i == 40) set_all(8'd255);
            tick();
            if (done) done_t.push_back(i);
            if (i == 91) chk("b2b_out1_hold", 64'(o1), 64'(B1));
            if (i == 92) chk("b2b_out1_new", 64'(o1), 64'(SAT));
        end
        start = 1'b0;
        tick();
        chk("b2b_pulses", 64'(done_t.size()), 64'd3);
        if (done_t.size() == 3) begin
            chk("b2b_first", 64'(done_t[0]), 64'd36);
            chk("b2b_gap1", 64'(done_t[1] - done_t[0]), 64'd37);
            chk("b2b_gap2", 64'(done_t[2] - done_t[1]), 64'd37);
        end
        chk("b2b_idle_busy", 64'(busy), 64'd0);
        chk("b2b_idle_done", 64'(done), 64'd0);

        // Start pulses at E5 and E36 are ignored
        set_baseline();
        pulse_start();
        done_cnt  = 0;
        busy_late = 1'b0;
        for (int i = 1; i <= 80; i++) begin
            start = (i == 5 || i == 36);
            tick();
            if (done) done_cnt++;
            if (i >= 37 && busy) busy_late = 1'b1;
            if (i == 36) chk("ign_done_e36", 64'(done), 64'd1);
        end
        start = 1'b0;
        chk("ign_one_done", 64'(done_cnt), 64'd1);
        chk("ign_no_rerun", 64'(busy_late), 64'd0);
        chk_outs("ign", B0, B1, B2, B3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
